// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU: ADD/SUB in one step, shift-add MUL, one-bit-per-cycle
// shifts; valid/ready request and result channels, no overlap.
module alu_seq_exec #(
  parameter int WIDTH     = 32,
  parameter int SHAMT_MAX = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opCode,
  input  logic [WIDTH-1:0] rSrc,
  input  logic [WIDTH-1:0] rDst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       psrOut,
  output logic             busy
);

  localparam logic [4:0] ALUOp_ADD = 5'h00;
  localparam logic [4:0] ALUOp_SUB = 5'h01;
  localparam logic [4:0] ALUOp_MUL = 5'h02;
  localparam logic [4:0] ALUOp_SLL = 5'h03;
  localparam logic [4:0] ALUOp_SRL = 5'h04;
  localparam logic [4:0] ALUOp_SRA = 5'h05;

  localparam int NMAX = (WIDTH > SHAMT_MAX) ? WIDTH : SHAMT_MAX;
  localparam int CW   = $clog2(NMAX + 1);
  localparam logic [WIDTH-1:0] SH_SAT = WIDTH'(SHAMT_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] res_q;
  logic [4:0]       psr_q;
  logic [CW-1:0]    cnt_q;
  logic             shen_q;

  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] res_d;
  logic [4:0]       psr_d;
  logic [WIDTH-1:0] bop;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             shc;
  logic             supp;
  logic [CW-1:0]    cnt_ld;

  assign in_ready  = (state_q == S_IDLE) && reset_n;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = res_q;
  assign psrOut    = psr_q;

  // SUB reuses the adder as a + ~b + 1
  always_comb begin
    bop = (op_q == ALUOp_SUB) ? ~b_q : b_q;
    {cout, sum} = {1'b0, a_q} + {1'b0, bop}
                + {{WIDTH{1'b0}}, (op_q == ALUOp_SUB)};
    ovf = (a_q[WIDTH-1] == bop[WIDTH-1])
       && (sum[WIDTH-1] != a_q[WIDTH-1]);
  end

  assign acc_d = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    shc   = 1'b0;
    res_d = '0;
    psr_d = '0;
    supp  = 1'b1;
    case (op_q)
      ALUOp_ADD: begin
        res_d    = sum;
        psr_d[2] = ovf;
        psr_d[0] = cout;
      end
      ALUOp_SUB: begin
        res_d    = sum;
        psr_d[2] = ovf;
        psr_d[1] = (a_q < b_q);
        psr_d[0] = cout;
      end
      ALUOp_MUL: begin
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        res_d = acc_d;
      end
      ALUOp_SLL: begin
        if (shen_q) begin
          a_d = a_q << 1;
          shc = a_q[WIDTH-1];
        end
        res_d    = a_d;
        psr_d[0] = shc;
      end
      ALUOp_SRL: begin
        if (shen_q) begin
          a_d = a_q >> 1;
          shc = a_q[0];
        end
        res_d    = a_d;
        psr_d[0] = shc;
      end
      ALUOp_SRA: begin
        if (shen_q) begin
          a_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
          shc = a_q[0];
        end
        res_d    = a_d;
        psr_d[0] = shc;
      end
      default: supp = 1'b0;
    endcase
    if (supp) begin
      psr_d[4] = res_d[WIDTH-1];
      psr_d[3] = (res_d == '0);
    end
  end

  // Zero-amount shifts still spend one step
  always_comb begin
    case (opCode)
      ALUOp_MUL: cnt_ld = CW'(WIDTH);
      ALUOp_SLL,
      ALUOp_SRL,
      ALUOp_SRA: begin
        if (rSrc == '0)
          cnt_ld = CW'(1);
        else if (rSrc >= SH_SAT)
          cnt_ld = CW'(SHAMT_MAX);
        else
          cnt_ld = rSrc[CW-1:0];
      end
      default: cnt_ld = CW'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      psr_q   <= '0;
      cnt_q   <= '0;
      shen_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= opCode;
            a_q     <= rDst;
            b_q     <= rSrc;
            acc_q   <= '0;
            cnt_q   <= cnt_ld;
            shen_q  <= (rSrc != '0);
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            res_q   <= res_d;
            psr_q   <= psr_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: directed vector table, multi-cycle corner
// sequences and random ops against a behavioural model.
module tb_alu_seq_exec;

  localparam logic [4:0] OP_ADD = 5'h00;
  localparam logic [4:0] OP_SUB = 5'h01;
  localparam logic [4:0] OP_MUL = 5'h02;
  localparam logic [4:0] OP_SLL = 5'h03;
  localparam logic [4:0] OP_SRL = 5'h04;
  localparam logic [4:0] OP_SRA = 5'h05;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  opCode = '0;
  logic [31:0] rSrc = '0;
  logic [31:0] rDst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  psrOut;
  logic        busy;

  int pass_cnt = 0;
  int total = 0;

  alu_seq_exec #(.WIDTH(32), .SHAMT_MAX(32)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .opCode(opCode),
    .rSrc(rSrc),
    .rDst(rDst),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .psrOut(psrOut),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] d;
    logic [31:0] s;
    logic [31:0] r;
    logic [4:0]  p;
    int          n;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: plain arithmetic on wide values, flags from their definitions
  function automatic void model(input logic [4:0] op,
                                input logic [31:0] d, input logic [31:0] s,
                                output logic [31:0] r,
                                output logic [4:0] p, output int n);
    longint      sd;
    longint      ss;
    longint      v;
    logic [32:0] t;
    logic [63:0] w;
    int          amt;
    logic        f, l, c;
    bit          sup;
    f = 0; l = 0; c = 0; r = '0; n = 1; sup = 1;
    sd = longint'($signed(d));
    ss = longint'($signed(s));
    amt = (s > 32'd32) ? 32 : int'(s);
    case (op)
      OP_ADD: begin
        t = {1'b0, d} + {1'b0, s};
        r = t[31:0]; c = t[32];
        v = sd + ss;
        f = (v != longint'($signed(r)));
      end
      OP_SUB: begin
        t = {1'b0, d} + {1'b0, ~s} + 33'd1;
        r = t[31:0]; c = t[32];
        v = sd - ss;
        f = (v != longint'($signed(r)));
        l = (d < s);
      end
      OP_MUL: begin
        r = d * s;
        n = 32;
      end
      OP_SLL: begin
        w = {32'h0, d} << amt;
        r = w[31:0];
        c = (amt == 0) ? 1'b0 : w[32];
        n = (amt == 0) ? 1 : amt;
      end
      OP_SRL: begin
        w = {d, 32'h0} >> amt;
        r = w[63:32];
        c = (amt == 0) ? 1'b0 : w[31];
        n = (amt == 0) ? 1 : amt;
      end
      OP_SRA: begin
        w = $signed({d, 32'h0}) >>> amt;
        r = w[63:32];
        c = (amt == 0) ? 1'b0 : w[31];
        n = (amt == 0) ? 1 : amt;
      end
      default: sup = 0;
    endcase
    p = sup ? {r[31], (r == 32'h0), f, l, c} : 5'h0;
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] d,
                       input logic [31:0] s, input int exp_n,
                       input string name);
    int w = 0;
    int e = 0;
    bit rdy_ok = 1;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    opCode = op; rDst = d; rSrc = s; in_valid = 1'b1;
    @(posedge clk); #1;
    if (in_ready) rdy_ok = 0;
    do begin
      in_valid = 1'($urandom);
      opCode = 5'($urandom);
      rSrc = $urandom;
      rDst = $urandom;
      @(posedge clk); #1; e++;
      if (in_ready) rdy_ok = 0;
    end while (!out_valid && e < 300);
    chk(e == exp_n, {name, " latency"}, 32'(e), 32'(exp_n));
    chk(rdy_ok, {name, " in_ready low while busy"}, 32'(!rdy_ok), 32'd0);
  endtask

  task automatic check_out(input logic [31:0] r, input logic [4:0] p,
                           input string name);
    chk(result == r, {name, " result"}, result, r);
    chk(psrOut == p, {name, " psr"}, 32'(psrOut), 32'(p));
  endtask

  // in_valid stays high on the out handshake edge; it must not be taken
  task automatic retire(input string name);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk(in_ready && !out_valid && !busy, {name, " retire"},
        32'({in_ready, out_valid, busy}), 32'b100);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] mr;
    logic [4:0]  mp;
    int          mn;
    logic [4:0]  rop;
    logic [31:0] rd, rs;
    bit          stable;

    vt[0]  = '{OP_ADD, 32'd2, 32'd2, 32'd4, 5'h00, 1};
    vt[1]  = '{OP_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 5'h14, 1};
    vt[2]  = '{OP_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 5'h12, 1};
    vt[3]  = '{OP_SUB, 32'd7, 32'd7, 32'd0, 5'h09, 1};
    vt[4]  = '{OP_MUL, 32'd6, 32'd6, 32'd36, 5'h00, 32};
    vt[5]  = '{OP_MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 5'h10, 32};
    vt[6]  = '{OP_SLL, 32'd5, 32'd7, 32'd640, 5'h00, 7};
    vt[7]  = '{OP_SRL, 32'd40132, 32'd7, 32'd313, 5'h01, 7};
    vt[8]  = '{OP_SRA, 32'hFFFFB15C, 32'd7, 32'hFFFFFF62, 5'h11, 7};
    vt[9]  = '{OP_SRA, 32'd20, 32'd3, 32'd2, 5'h01, 3};
    vt[10] = '{OP_SRA, 32'h80000000, 32'd40, 32'hFFFFFFFF, 5'h11, 32};
    vt[11] = '{OP_SLL, 32'h00001234, 32'd0, 32'h00001234, 5'h00, 1};
    vt[12] = '{5'h1F, 32'd3, 32'd4, 32'd0, 5'h00, 1};
    vt[13] = '{OP_SRL, 32'h80000000, 32'd31, 32'd1, 5'h00, 31};
    vt[14] = '{OP_SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF, 5'h05, 1};

    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(!in_ready, "reset in_ready", 32'(in_ready), 32'd0);
    chk(!out_valid && !busy, "reset valid/busy",
        32'({out_valid, busy}), 32'd0);
    chk(result == 32'd0, "reset result", result, 32'd0);
    chk(psrOut == 5'd0, "reset psr", 32'(psrOut), 32'd0);
    in_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk(in_ready, "idle in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 15; i++) begin
      issue(vt[i].op, vt[i].d, vt[i].s, vt[i].n, $sformatf("vec%0d", i));
      check_out(vt[i].r, vt[i].p, $sformatf("vec%0d", i));
      retire($sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while the consumer stalls
    issue(OP_ADD, 32'd10, 32'd20, 1, "bp");
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(i);
      out_ready = 1'b0;
      @(posedge clk); #1;
      if (result != 32'd30 || psrOut != 5'd0 || !out_valid || in_ready)
        stable = 0;
    end
    chk(stable, "bp hold", 32'(!stable), 32'd0);
    check_out(32'd30, 5'h00, "bp");
    retire("bp");
    issue(OP_SUB, 32'd3, 32'd1, 1, "bp next");
    check_out(32'd2, 5'h01, "bp next");
    retire("bp next");

    // Reset in the 10th BUSY cycle of a MUL
    opCode = OP_MUL; rDst = 32'd123; rSrc = 32'd456; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk(busy && !out_valid, "mul running", 32'({busy, out_valid}), 32'b10);
    reset_n = 1'b0;
    #1;
    chk(!in_ready, "midrst in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk(!out_valid && !busy, "midrst state",
        32'({out_valid, busy}), 32'd0);
    chk(result == 32'd0, "midrst result", result, 32'd0);
    chk(psrOut == 5'd0, "midrst psr", 32'(psrOut), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    issue(OP_ADD, 32'd2, 32'd2, 1, "post rst");
    check_out(32'd4, 5'h00, "post rst");
    retire("post rst");

    for (int i = 0; i < 40; i++) begin
      int k;
      k = int'($urandom_range(0, 6));
      rop = (k == 6) ? 5'(5'h10 + $urandom_range(0, 15)) : 5'(k);
      rd = $urandom;
      if (rop >= OP_SLL && rop <= OP_SRA && $urandom_range(0, 3) != 0)
        rs = $urandom_range(0, 40);
      else
        rs = $urandom;
      model(rop, rd, rs, mr, mp, mn);
      issue(rop, rd, rs, mn, $sformatf("rnd%0d op%0d", i, rop));
      check_out(mr, mp, $sformatf("rnd%0d op%0d", i, rop));
      retire($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Multi-cycle, handshaked ALU execution unit. It is the responder that receives operation requests from the datapath/controller.
- Performs ADD, SUB, MUL, SLL, SRL and SRA on 32-bit operands.
  - MUL uses iterative shift-add.
  - Shifts move one bit per cycle.
- Returns a registered result and PSR flags over a valid/ready output channel.
- Sits between the register-file read stage and writeback. It uses the same `ALUOp_*` opcode codes and PSR layout as the combinational alu.

Parameters:
- WIDTH, 32, operand/result width (MUL iteration count = WIDTH)
- SHAMT_MAX, 32, saturation limit for shift iterations

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit idle, can accept request
- opCode  in  5  `ALUOp_*` code, sampled at accept
- rSrc  in  WIDTH  source operand (shift amount for shifts)
- rDst  in  WIDTH  destination operand
- out_valid  out  1  result/psrOut valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- psrOut  out  5  flags {N,Z,F,L,C} = bits [4:0]
- busy  out  1  high in BUSY or DONE

Behaviour:
- Reset (reset_n low at an edge):
  - state IDLE; result=0, psrOut=0, out_valid=0, internal counters cleared.
  - in_ready is forced low while reset_n is low.
  - Reset mid-operation abandons the operation; no result is produced.
- States: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE) && reset_n.
  - out_valid = (state==DONE).
- IDLE: on an edge with in_valid && in_ready, latch opCode/rSrc/rDst, load the step count N, go to BUSY.
- BUSY: one step per edge. After the Nth step, write result/psrOut and enter DONE.
  - out_valid is therefore first high N edges after the accept edge.
- DONE: result/psrOut held stable. On an edge with out_ready high, go to IDLE; in_ready is high the following cycle.
  - in_valid is ignored in BUSY/DONE; there is no pipelining and no overlap.
- N per op:
  - ADD/SUB: 1.
  - MUL: WIDTH.
  - SLL/SRL/SRA: min(rSrc unsigned, SHAMT_MAX); an amount of 0 still takes 1 step with no shift.
  - Unsupported opcode: 1.
- ADD: rDst+rSrc. SUB: rDst-rSrc, computed as rDst + ~rSrc + 1.
- MUL: low WIDTH bits of rDst*rSrc via 32 shift-add steps. Signed and unsigned results are identical.
- SLL/SRL: zero fill. SRA: sign fill. Amounts ≥32 give 0 (SLL/SRL) or all copies of the sign bit (SRA).
- Flags:
  - N = result[WIDTH-1] and Z = (result==0) for all supported ops.
  - C = carry out of the adder (ADD/SUB), or the last bit shifted out (shifts; 0 if amount 0).
  - F = signed overflow (ADD/SUB).
  - L = rDst < rSrc unsigned (SUB only).
  - Flags not listed for an op are 0.
- Unsupported opcode: result=0, psrOut=0, still completes the handshake.
- Simultaneous out_ready with new in_valid in DONE: the new request is not accepted that cycle.

Test Plan:
- Reset, then ADD rDst=2, rSrc=2 → out_valid exactly 1 edge after accept; result=4, psrOut=0; in_ready high the cycle after the out handshake.
- ADD 0x7FFFFFFF+1 → result 0x80000000, N=1, F=1, C=0. SUB rDst=5, rSrc=7 → result -2, N=1, L=1, C=0. SUB 7-7 → 0, Z=1, C=1.
- MUL 6*6 → 36 after 32 edges. MUL -3*7 → 0xFFFFFFEB, N=1. in_ready stays low and in_valid is ignored throughout.
- Shifts:
  - SLL 5<<7 → 640 after 7 edges, C=0.
  - SRL 40132>>7 → 313, C=1.
  - SRA -20132>>>7 → -158, N=1.
  - SRA 20>>>3 → 2.
  - SRA 0x80000000 by 40 → 0xFFFFFFFF after 32 edges.
  - SLL by 0 → unchanged after 1 edge, C=0.
- Backpressure: hold out_ready low for 5 cycles in DONE with in_valid toggling → result/psrOut stable, no accept. Raise out_ready → IDLE next edge, next request correct.
- Drop reset_n at the 10th BUSY cycle of a MUL → out_valid=0, result=0, psrOut=0, in_ready low during reset. After release, ADD 2+2 → 4.
